// File: rtl/rs_debounce_driver.sv
// rs_debounce_driver
// Synchronizes and debounces two raw button inputs (set, reset), turns the
// rising edge of each debounced level into a one-cycle pulse for a downstream
// RS latch, and tracks the value that latch is expected to hold.
// Simultaneous rises are reported on conflict instead of driving s and r
// together, so the latch never sees its forbidden input.
// Channel 0 is set_btn, channel 1 is reset_btn.

module rs_debounce_driver #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic reset_btn,
    output logic s,
    output logic r,
    output logic conflict,
    output logic state
);

    // Last counter value before the debounced level is allowed to flip.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [1:0]            raw;
    logic [1:0]            meta_q;
    logic [1:0]            sync_q;
    logic [1:0]            db_q;
    logic [1:0]            db_d;
    logic [1:0]            db_prev_q;
    logic [1:0][CNT_W-1:0] cnt_q;
    logic [1:0][CNT_W-1:0] cnt_d;
    logic [1:0]            rise;
    logic                  s_q, s_d;
    logic                  r_q, r_d;
    logic                  conflict_q, conflict_d;
    logic                  state_q, state_d;

    assign raw = {reset_btn, set_btn};

    // Per-channel debounce: flip db only after DEBOUNCE consecutive mismatches.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (sync_q[ch] == db_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                db_d[ch]  = sync_q[ch];
                cnt_d[ch] = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + 1'b1;
            end
        end
    end

    // Edge arbitration: a lone rise pulses its output, a double rise only flags.
    always_comb begin
        rise       = db_q & ~db_prev_q;
        s_d        = rise[0] & ~rise[1];
        r_d        = rise[1] & ~rise[0];
        conflict_d = rise[0] & rise[1];
        if (s_q) begin
            state_d = 1'b1;
        end else if (r_q) begin
            state_d = 1'b0;
        end else begin
            state_d = state_q;
        end
    end

    // All state registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            db_q       <= '0;
            db_prev_q  <= '0;
            cnt_q      <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            state_q    <= 1'b0;
        end else begin
            meta_q     <= raw;
            sync_q     <= meta_q;
            db_q       <= db_d;
            db_prev_q  <= db_q;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
            state_q    <= state_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;
    assign state    = state_q;

endmodule

// File: tb/tb_rs_debounce_driver.sv
// Bench for rs_debounce_driver: directed latency/bounce/conflict/reset checks
// with literal expectations, plus a randomized phase compared every cycle
// against an edge-history reference model.

module tb_rs_debounce_driver;

    localparam int DEBOUNCE = 4;
    localparam int CNT_W    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_btn = 1'b0;
    logic reset_btn = 1'b0;
    logic s, r, conflict, state;

    int checks = 0;
    int errors = 0;

    rs_debounce_driver #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
        .s(s), .r(r), .conflict(conflict), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model. Per edge n (counting sampled raw values):
    //   the debouncer sees the raw value sampled two edges earlier;
    //   the level flips once it has disagreed for DEBOUNCE edges in a row;
    //   a pulse follows the edge after the level rose.
    bit          raw1_m[2], raw2_m[2];
    bit          lvl_m[2], lvl_prev_m[2];
    int unsigned run_m[2];
    bit          ms, mr, mc, mstate;

    always @(posedge clk or posedge rst) begin
        bit          rise[2];
        bit          cur[2];
        bit          lvl_n[2];
        int unsigned run_n[2];
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                raw1_m[c] <= 0; raw2_m[c] <= 0; lvl_m[c] <= 0;
                lvl_prev_m[c] <= 0; run_m[c] <= 0;
            end
            ms <= 0; mr <= 0; mc <= 0; mstate <= 0;
        end else begin
            cur[0] = set_btn;
            cur[1] = reset_btn;
            for (int c = 0; c < 2; c++) begin
                rise[c]  = lvl_m[c] && !lvl_prev_m[c];
                lvl_n[c] = lvl_m[c];
                run_n[c] = 0;
                if (raw2_m[c] != lvl_m[c]) begin
                    run_n[c] = run_m[c] + 1;
                    if (run_n[c] == DEBOUNCE) begin
                        lvl_n[c] = raw2_m[c];
                        run_n[c] = 0;
                    end
                end
                lvl_prev_m[c] <= lvl_m[c];
                lvl_m[c]      <= lvl_n[c];
                run_m[c]      <= run_n[c];
                raw2_m[c]     <= raw1_m[c];
                raw1_m[c]     <= cur[c];
            end
            if (ms)      mstate <= 1;
            else if (mr) mstate <= 0;
            ms <= rise[0] && !rise[1];
            mr <= rise[1] && !rise[0];
            mc <= rise[0] && rise[1];
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_s", s, ms);
            chk("cyc_r", r, mr);
            chk("cyc_conflict", conflict, mc);
            chk("cyc_state", state, mstate);
            chk("cyc_s_and_r", s & r, 0);
        end
    end

    // Advance to 3 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Wait for a pulse on the selected output; returns tick index (1-based) or -1.
    task automatic wait_pulse(input int which, input int budget, output int at);
        at = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (at < 0 && ((which == 0 && s) || (which == 1 && r) || (which == 2 && conflict)))
                at = i;
        end
    endtask

    initial begin
        int at;
        int pulses;
        ticks(2);
        rst = 1'b0;

        // Idle after reset: all outputs stay low.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            pulses += s + r + conflict + state;
        end
        chk("idle_outputs", pulses, 0);

        // Clean set: s after edge k+6 (7th tick), state from k+7, one pulse only.
        set_btn = 1'b1;
        pulses = 0;
        at = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (s) begin pulses++; if (at < 0) at = i; end
            if (i == 7) chk("set_state_before", state, 0);
            if (i == 8) chk("set_state_after", state, 1);
        end
        chk("set_latency", at, 7);
        chk("set_single_pulse", pulses, 1);
        set_btn = 1'b0;
        ticks(15);

        // Bouncing set: 3 high / 3 low, five times -> nothing.
        pulses = 0;
        for (int rep = 0; rep < 5; rep++) begin
            set_btn = 1'b1;
            for (int i = 0; i < 3; i++) begin tick(); pulses += s; end
            set_btn = 1'b0;
            for (int i = 0; i < 3; i++) begin tick(); pulses += s; end
        end
        for (int i = 0; i < 10; i++) begin tick(); pulses += s; end
        chk("bounce_no_pulse", pulses, 0);
        chk("bounce_state", state, 1);

        // Clean reset: r after edge k+6, state 0 from k+7.
        reset_btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) chk("reset_r_pulse", r, 1);
            if (i == 7) chk("reset_state_before", state, 1);
            if (i == 8) chk("reset_state_after", state, 0);
        end
        reset_btn = 1'b0;
        ticks(15);

        // Simultaneous rises: conflict at k+6, no s/r, state unchanged.
        set_btn = 1'b1;
        reset_btn = 1'b1;
        pulses = 0;
        at = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            pulses += s + r;
            if (at < 0 && conflict) at = i;
        end
        chk("conflict_latency", at, 7);
        chk("conflict_no_sr", pulses, 0);
        chk("conflict_state", state, 0);

        // Rise on set while reset level held high still pulses.
        set_btn = 1'b0;
        ticks(15);
        set_btn = 1'b1;
        wait_pulse(0, 12, at);
        chk("held_other_set", at, 7);
        set_btn = 1'b0;
        reset_btn = 1'b0;
        ticks(15);
        chk("pre_rst_state", state, 1);

        // Reset mid-debounce with set held: immediate clear, re-debounce after release.
        set_btn = 1'b1;
        ticks(5);
        rst = 1'b1;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_s", s | r | conflict, 0);
        ticks(2);
        rst = 1'b0;
        wait_pulse(0, 12, at);
        chk("rst_release_latency", at, 7);
        set_btn = 1'b0;
        ticks(15);

        // Randomized phase with bounces and occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            set_btn   = 1'($urandom_range(0, 1));
            reset_btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                ticks(1 + $urandom_range(0, 1));
                rst = 1'b0;
            end
            ticks(1 + $urandom_range(0, 11));
        end
        set_btn = 1'b0;
        reset_btn = 1'b0;
        ticks(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
